hvsync_generator: RTL and testbench
===================================

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_BOTTOM, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_TOP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk  input  1  pixel clock, all state changes on its rising edge.
REQ-010 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-011 SHALL have port hsync  output  1  horizontal sync, active low.
REQ-012 SHALL have port vsync  output  1  vertical sync, active low.
REQ-013 SHALL have port display_on  output  1  high while the pixel is in the visible area.
REQ-014 SHALL have port hpos  output  10  current pixel column.
REQ-015 SHALL have port vpos  output  10  current line.
REQ-016 SHALL have port frame_start  output  1  one-clock frame pulse, present only when HVSYNC_FRAME_TICK_EN is defined.

Function
REQ-017 SHALL define H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 (799) and V_MAX = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP-1 (524).
REQ-018 SHALL increment hpos by 1 every clk; at hpos==H_MAX, hpos wraps to 0 on the next edge.
REQ-019 SHALL increment vpos by 1 on the same edge as the hpos wrap; vpos holds otherwise.
REQ-020 SHALL wrap vpos to 0 when hpos==H_MAX and vpos==V_MAX together, so hpos=0, vpos=0 on the next edge.
REQ-021 SHALL never drive hpos above H_MAX or vpos above V_MAX.
REQ-022 SHALL drive hsync low exactly when H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751), with the same cycle as the hpos value and zero lag.
REQ-023 SHALL drive vsync low exactly when V_DISPLAY+V_BOTTOM <= vpos <= V_DISPLAY+V_BOTTOM+V_SYNC-1 (490..491), for all hpos of those lines.
REQ-024 SHALL drive display_on high exactly when hpos < H_DISPLAY and vpos < V_DISPLAY, in the same cycle.
REQ-025 SHALL drive hsync, vsync and display_on from flops or from decoding of registered counters only, with no combinational path from any input.
REQ-026 SHALL produce a period of 800 clocks per line and 420000 clocks per frame with default parameters.

Reset
REQ-027 SHALL asynchronously force hpos=0 and vpos=0 while rst_n is low.
REQ-028 SHALL drive hsync=1, vsync=1 and display_on=1 while rst_n is low, with frame_start=0 if present.
REQ-029 SHALL start counting on the first rising clk edge after rst_n deasserts, moving to hpos=1.
REQ-030 SHALL abandon the current frame when reset is asserted mid-frame and restart from 0,0 with no partial-state carryover.

Configuration
REQ-031 SHALL use the macro HVSYNC_FRAME_TICK_EN: when defined, it adds output frame_start, high for exactly one clock when hpos==0 and vpos==0 in the same cycle, excluding the cycles while rst_n is low.
REQ-032 SHALL omit the frame_start port and its logic when HVSYNC_FRAME_TICK_EN is undefined, with all other behaviour identical.

Verification
REQ-033 SHALL cover this scenario: reset low then released -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=1; after 1 clk hpos=1.
REQ-034 SHALL cover this scenario: run 800 clks from 0,0 -> hpos=0, vpos=1; hsync low for exactly the 96 cycles at hpos 656..751.
REQ-035 SHALL cover this scenario: run to hpos=639 then hpos=640 on line 0 -> display_on 1 then 0; vpos=480 -> display_on 0 for the whole line.
REQ-036 SHALL cover this scenario: run one full frame -> vsync low only on vpos 490..491 (1600 clks), then the position wraps to 0,0 after 420000 clks.
REQ-037 SHALL cover this scenario: assert rst_n low at hpos=300, vpos=200 without a clock edge -> outputs return to reset values immediately.
REQ-038 SHALL cover this scenario: HVSYNC_FRAME_TICK_EN defined, two frames run -> frame_start pulses exactly once per 420000 clks, each pulse one clock wide, aligned to hpos=0, vpos=0.

Source files
------------

// File: rtl/hvsync_generator.sv
// hvsync_generator: VGA-style pixel/line counters with active-low sync and visible-area decode.
// Optional one-clock frame_start output is enabled by defining HVSYNC_FRAME_TICK_EN.
module hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
`ifdef HVSYNC_FRAME_TICK_EN
    ,
    output logic       frame_start
`endif
);
    localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       h_wrap;

    always_comb begin
        h_wrap = (hpos_q == H_MAX);
        hpos_d = h_wrap ? '0 : hpos_q + 10'd1;
        vpos_d = !h_wrap ? vpos_q : (vpos_q == V_MAX) ? '0 : vpos_q + 10'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    // Everything below decodes the registered counters, so reset values follow from 0,0.
    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = !((hpos_q >= HS_START) && (hpos_q <= HS_END));
    assign vsync      = !((vpos_q >= VS_START) && (vpos_q <= VS_END));
    assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

`ifdef HVSYNC_FRAME_TICK_EN
    // Gated by rst_n so the 0,0 position held during reset does not pulse.
    assign frame_start = rst_n && (hpos_q == '0) && (vpos_q == '0);
`endif
endmodule

// File: tb/tb_hvsync_generator.sv
// tb_hvsync_generator: scoreboard bench with a scaled-timing instance (32 clk x 17 lines) and a default-timing instance.
module tb_hvsync_generator;
    typedef struct {
        int dut;
        int cyc;
        int hp;
        int vp;
        int hs;
        int vs;
        int de;
        int fs;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [9:0] hp_s, vp_s, hp_d, vp_d;
    logic hs_s, vs_s, de_s, hs_d, vs_d, de_d;
    logic fs_s, fs_d;
    int cyc;
    int seg;
    int n_chk, n_fail;
    int hs_cnt_s, vs_cnt_s, de_l10, hs_cnt_d, over_cnt, fs_cnt, fs_bad;
    exp_t q[$];

    hvsync_generator #(
        .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(2),
        .V_DISPLAY(10), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(3)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .hsync(hs_s), .vsync(vs_s), .display_on(de_s),
        .hpos(hp_s), .vpos(vp_s)
`ifdef HVSYNC_FRAME_TICK_EN
        , .frame_start(fs_s)
`endif
    );

    hvsync_generator dut_d (
        .clk(clk), .rst_n(rst_n), .hsync(hs_d), .vsync(vs_d), .display_on(de_d),
        .hpos(hp_d), .vpos(vp_d)
`ifdef HVSYNC_FRAME_TICK_EN
        , .frame_start(fs_d)
`endif
    );

`ifndef HVSYNC_FRAME_TICK_EN
    assign fs_s = 1'b0;
    assign fs_d = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_entry(exp_t e);
        string t;
        t = $sformatf("%s c%0d", e.dut == 0 ? "scaled" : "default", e.cyc);
        cmp({t, " hpos"}, e.dut == 0 ? 32'(hp_s) : 32'(hp_d), e.hp);
        cmp({t, " vpos"}, e.dut == 0 ? 32'(vp_s) : 32'(vp_d), e.vp);
        cmp({t, " hsync"}, e.dut == 0 ? 32'(hs_s) : 32'(hs_d), e.hs);
        cmp({t, " vsync"}, e.dut == 0 ? 32'(vs_s) : 32'(vs_d), e.vs);
        cmp({t, " display_on"}, e.dut == 0 ? 32'(de_s) : 32'(de_d), e.de);
`ifdef HVSYNC_FRAME_TICK_EN
        cmp({t, " frame_start"}, e.dut == 0 ? 32'(fs_s) : 32'(fs_d), e.fs);
`endif
    endtask

    // Reset-time entries carry cyc=-1 and are checked 1 time unit after rst_n falls.
    task automatic exp_v(int d, int c, int hp, int vp, int hs, int vs, int de);
        exp_t e;
        e.dut = d; e.cyc = c; e.hp = hp; e.vp = vp;
        e.hs = hs; e.vs = vs; e.de = de;
        e.fs = (c >= 0 && hp == 0 && vp == 0) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic wait_cyc(int n);
        int k;
        k = 0;
        while (cyc != n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            $display("FAIL wait_cyc: cycle %0d not reached, at %0d", n, cyc);
            $fatal(1);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            while (q.size() > 0 && q[0].cyc < 0) check_entry(q.pop_front());
        end else begin
            while (q.size() > 0 && q[0].cyc == cyc) check_entry(q.pop_front());
            if (seg == 2) begin
                if (cyc < 32 && !hs_s) hs_cnt_s++;
                if (cyc < 544 && !vs_s) vs_cnt_s++;
                if (cyc >= 320 && cyc < 352 && de_s) de_l10++;
                if (cyc < 800 && !hs_d) hs_cnt_d++;
                if (hp_s > 31 || vp_s > 16 || hp_d > 799 || vp_d > 524) over_cnt++;
                if (cyc < 1200 && fs_s) begin
                    fs_cnt++;
                    if (hp_s != 0 || vp_s != 0) fs_bad++;
                end
                if (fs_d && (hp_d != 0 || vp_d != 0)) fs_bad++;
                if (cyc == 1700) begin
                    cmp("scaled hsync low clocks on line 0", hs_cnt_s, 6);
                    cmp("scaled vsync low clocks per frame", vs_cnt_s, 64);
                    cmp("scaled display_on clocks on line V_DISPLAY", de_l10, 0);
                    cmp("default hsync low clocks on line 0", hs_cnt_d, 96);
                    cmp("position above max", over_cnt, 0);
`ifdef HVSYNC_FRAME_TICK_EN
                    cmp("scaled frame_start pulses in 1200 clocks", fs_cnt, 3);
                    cmp("frame_start off 0,0", fs_bad, 0);
`endif
                    cmp("scoreboard leftover entries", q.size(), 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        seg = 1;
        {n_chk, n_fail, hs_cnt_s, vs_cnt_s, de_l10, hs_cnt_d, over_cnt, fs_cnt, fs_bad} = '0;
        exp_v(0, -1, 0, 0, 1, 1, 1);
        exp_v(1, -1, 0, 0, 1, 1, 1);
        // Scaled timing: H_MAX=31, hsync 24..29, V_MAX=16, vsync 12..13, visible 20x10.
        exp_v(0, 0, 0, 0, 1, 1, 1);     exp_v(1, 0, 0, 0, 1, 1, 1);
        exp_v(0, 1, 1, 0, 1, 1, 1);     exp_v(1, 1, 1, 0, 1, 1, 1);
        exp_v(0, 19, 19, 0, 1, 1, 1);   exp_v(0, 20, 20, 0, 1, 1, 0);
        exp_v(0, 23, 23, 0, 1, 1, 0);   exp_v(0, 24, 24, 0, 0, 1, 0);
        exp_v(0, 29, 29, 0, 0, 1, 0);   exp_v(0, 30, 30, 0, 1, 1, 0);
        exp_v(0, 31, 31, 0, 1, 1, 0);   exp_v(0, 32, 0, 1, 1, 1, 1);
        exp_v(0, 320, 0, 10, 1, 1, 0);  exp_v(0, 383, 31, 11, 1, 1, 0);
        exp_v(0, 384, 0, 12, 1, 0, 0);  exp_v(0, 447, 31, 13, 1, 0, 0);
        exp_v(0, 448, 0, 14, 1, 1, 0);  exp_v(0, 543, 31, 16, 1, 1, 0);
        exp_v(0, 544, 0, 0, 1, 1, 1);   exp_v(0, 545, 1, 0, 1, 1, 1);
        exp_v(0, 761, 25, 6, 0, 1, 0);  exp_v(1, 761, 761, 0, 1, 1, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_cyc(761);
        exp_v(0, -1, 0, 0, 1, 1, 1);
        exp_v(1, -1, 0, 0, 1, 1, 1);
        #2 rst_n = 1'b0;
        #3;
        seg = 2;
        exp_v(0, 0, 0, 0, 1, 1, 1);       exp_v(1, 0, 0, 0, 1, 1, 1);
        exp_v(0, 1, 1, 0, 1, 1, 1);       exp_v(1, 1, 1, 0, 1, 1, 1);
        exp_v(0, 544, 0, 0, 1, 1, 1);
        exp_v(1, 639, 639, 0, 1, 1, 1);   exp_v(1, 640, 640, 0, 1, 1, 0);
        exp_v(1, 655, 655, 0, 1, 1, 0);   exp_v(1, 656, 656, 0, 0, 1, 0);
        exp_v(1, 751, 751, 0, 0, 1, 0);   exp_v(1, 752, 752, 0, 1, 1, 0);
        exp_v(1, 799, 799, 0, 1, 1, 0);   exp_v(1, 800, 0, 1, 1, 1, 1);
        exp_v(0, 1088, 0, 0, 1, 1, 1);    exp_v(1, 1600, 0, 2, 1, 1, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_cyc(1702);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
